// File: rtl/riscmodified_regfile.sv
// 8 x 16-bit register file, R0 hardwired to zero, two registered read ports with write bypass.
// One-cycle read latency; Stall freezes both read outputs but never blocks a write.
module riscmodified_regfile #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [$clog2(DEPTH)-1:0] RdAddrA,
   input  logic [$clog2(DEPTH)-1:0] RdAddrB,
   input  logic                     Stall,
   input  logic                     WrEn,
   input  logic [$clog2(DEPTH)-1:0] WrAddr,
   input  logic [WIDTH-1:0]         WrData,
   output logic [WIDTH-1:0]         RdDataA,
   output logic [WIDTH-1:0]         RdDataB,
   output logic                     ZeroWrite
);

   localparam int AW = $clog2(DEPTH);

   // R0 has no storage; index 0 simply never matches any entry below.
   logic [WIDTH-1:0] regs_q [1:DEPTH-1];
   logic [WIDTH-1:0] regs_d [1:DEPTH-1];
   logic [WIDTH-1:0] rd_a_q, rd_a_d;
   logic [WIDTH-1:0] rd_b_q, rd_b_d;
   logic             zero_wr_q, zero_wr_d;

   always_comb begin
      regs_d    = regs_q;
      zero_wr_d = WrEn && (WrAddr == '0);
      for (int i = 1; i < DEPTH; i++) begin
         if (WrEn && (WrAddr == AW'(i))) begin
            regs_d[i] = WrData;
         end
      end
   end

   // Each port resolves independently; a same-cycle write to the read address wins over storage.
   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (!Stall) begin
         rd_a_d = '0;
         rd_b_d = '0;
         for (int i = 1; i < DEPTH; i++) begin
            if (RdAddrA == AW'(i)) begin
               rd_a_d = (WrEn && (WrAddr == AW'(i))) ? WrData : regs_q[i];
            end
            if (RdAddrB == AW'(i)) begin
               rd_b_d = (WrEn && (WrAddr == AW'(i))) ? WrData : regs_q[i];
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 1; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         rd_a_q    <= '0;
         rd_b_q    <= '0;
         zero_wr_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         rd_a_q    <= rd_a_d;
         rd_b_q    <= rd_b_d;
         zero_wr_q <= zero_wr_d;
      end
   end

   assign RdDataA   = rd_a_q;
   assign RdDataB   = rd_b_q;
   assign ZeroWrite = zero_wr_q;

endmodule

// File: tb/tb_riscmodified_regfile.sv
// Table-driven and randomized checks of riscmodified_regfile against an array-based model.
module tb_riscmodified_regfile;

   logic        Clk;
   logic        Reset;
   logic [2:0]  RdAddrA;
   logic [2:0]  RdAddrB;
   logic        Stall;
   logic        WrEn;
   logic [2:0]  WrAddr;
   logic [15:0] WrData;
   logic [15:0] RdDataA;
   logic [15:0] RdDataB;
   logic        ZeroWrite;

   riscmodified_regfile #(.WIDTH(16), .DEPTH(8)) dut (
      .Clk(Clk), .Reset(Reset), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
      .Stall(Stall), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
      .RdDataA(RdDataA), .RdDataB(RdDataB), .ZeroWrite(ZeroWrite)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   typedef struct {
      logic        rst;
      logic        wen;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic        stall;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        ez;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: what each register holds, and what each output should show.
   logic [15:0] mem [8];
   logic [15:0] m_a, m_b;
   logic        m_z;

   function automatic vec_t mk(input logic rst, input logic wen, input logic [2:0] wa,
                               input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                               input logic stall, input logic [15:0] ea, input logic [15:0] eb,
                               input logic ez);
      vec_t v;
      v.rst = rst; v.wen = wen; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
      v.stall = stall; v.ea = ea; v.eb = eb; v.ez = ez;
      return v;
   endfunction

   function automatic logic [15:0] model_read(input logic [2:0] addr);
      if (addr == 3'd0) return 16'h0000;
      if (WrEn && WrAddr == addr) return WrData;
      return mem[addr];
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model by one edge, sample 1 time unit after the edge.
   task automatic apply(input logic rst, input logic wen, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic stall);
      Reset = rst; WrEn = wen; WrAddr = wa; WrData = wd;
      RdAddrA = ra; RdAddrB = rb; Stall = stall;
      if (rst) begin
         foreach (mem[i]) mem[i] = 16'h0000;
         m_a = 16'h0000; m_b = 16'h0000; m_z = 1'b0;
      end else begin
         if (!stall) begin
            m_a = model_read(ra);
            m_b = model_read(rb);
         end
         m_z = wen && (wa == 3'd0);
         if (wen && wa != 3'd0) mem[wa] = wd;
      end
      @(posedge Clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      Reset = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0;
      RdAddrA = '0; RdAddrB = '0; Stall = 1'b0;
      foreach (mem[i]) mem[i] = 16'h0000;
      m_a = '0; m_b = '0; m_z = 1'b0;

      //           rst wen wa  wd        ra  rb  stl  ea        eb        ez
      tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 3, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(1, 0, 0, 16'h0000, 3, 3, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 3, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 5, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 5, 0, 16'h0000, 16'h1234, 0));
      tbl.push_back(mk(0, 1, 2, 16'h0001, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 2, 16'hA5A5, 2, 2, 0, 16'hA5A5, 16'hA5A5, 0));
      tbl.push_back(mk(0, 1, 0, 16'hFFFF, 0, 0, 0, 16'h0000, 16'h0000, 1));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 0, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 1));
      tbl.push_back(mk(0, 1, 1, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h1111, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 1, 16'h2222, 4, 0, 1, 16'h1111, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h2222, 16'h0000, 0));
      tbl.push_back(mk(1, 1, 6, 16'h7777, 6, 6, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 6, 6, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 1, 7, 16'hCAFE, 0, 0, 0, 16'h0000, 16'h0000, 0));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 7, 7, 0, 16'hCAFE, 16'hCAFE, 0));
      tbl.push_back(mk(0, 1, 0, 16'h9999, 0, 3, 1, 16'hCAFE, 16'hCAFE, 1));
      tbl.push_back(mk(0, 0, 0, 16'h0000, 3, 7, 0, 16'h0000, 16'hCAFE, 0));
      tbl.push_back(mk(1, 1, 7, 16'h4444, 7, 7, 1, 16'h0000, 16'h0000, 0));

      foreach (tbl[k]) begin
         apply(tbl[k].rst, tbl[k].wen, tbl[k].wa, tbl[k].wd, tbl[k].ra, tbl[k].rb, tbl[k].stall);
         chk($sformatf("tbl%0d.RdDataA", k), RdDataA, tbl[k].ea);
         chk($sformatf("tbl%0d.RdDataB", k), RdDataB, tbl[k].eb);
         chk($sformatf("tbl%0d.ZeroWrite", k), {15'd0, ZeroWrite}, {15'd0, tbl[k].ez});
      end

      // Bypass covers only the write of the same cycle; earlier writes come from storage.
      apply(0, 1, 4, 16'h5555, 4, 0, 0);
      chk("seq.byp1A", RdDataA, 16'h5555);
      apply(0, 1, 4, 16'h6666, 4, 4, 0);
      chk("seq.byp2A", RdDataA, 16'h6666);
      chk("seq.byp2B", RdDataB, 16'h6666);
      apply(0, 1, 3, 16'h0101, 4, 3, 0);
      chk("seq.storedA", RdDataA, 16'h6666);
      chk("seq.bypB", RdDataB, 16'h0101);
      apply(0, 0, 0, 16'h0000, 3, 4, 0);
      chk("seq.readA", RdDataA, 16'h0101);
      chk("seq.readB", RdDataB, 16'h6666);

      for (int n = 0; n < 400; n++) begin
         apply(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 7)), 16'($urandom),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               $urandom_range(0, 3) == 0);
         chk("rnd.RdDataA", RdDataA, m_a);
         chk("rnd.RdDataB", RdDataB, m_b);
         chk("rnd.ZeroWrite", {15'd0, ZeroWrite}, {15'd0, m_z});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
